// File: rtl/vec_alu_arbiter.sv
// Two-requester round-robin front end for a shared, fixed-latency vector ALU.
// One operation is in flight at a time; the result is held until the response is taken.
module vec_alu_arbiter #(
  parameter int vector_size = 256,
  parameter int element     = 16,
  parameter int alu_latency = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  input  logic                   req1_valid,
  output logic                   req0_ready,
  output logic                   req1_ready,
  input  logic [vector_size-1:0] req0_a,
  input  logic [vector_size-1:0] req0_b,
  input  logic [vector_size-1:0] req1_a,
  input  logic [vector_size-1:0] req1_b,
  input  logic [2:0]             req0_op,
  input  logic [2:0]             req1_op,
  output logic [vector_size-1:0] alu_a,
  output logic [vector_size-1:0] alu_b,
  output logic [2:0]             alu_op,
  input  logic [vector_size-1:0] alu_result,
  output logic                   resp_valid,
  output logic                   resp_id,
  output logic [vector_size-1:0] resp_data,
  input  logic                   resp_ready,
  output logic                   busy
);

  if (((vector_size % element) != 0) || (alu_latency < 1) || (alu_latency > 15)) begin : g_param_check
    $error("vec_alu_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] lat_load = 4'(alu_latency - 1);

  state_t                 state_r;
  logic                   last_grant_r;
  logic                   resp_id_r;
  logic [vector_size-1:0] resp_data_r;
  logic [vector_size-1:0] a_r;
  logic [vector_size-1:0] b_r;
  logic [2:0]             op_r;
  logic [3:0]             cnt_r;
  logic                   resp_valid_r;
  logic                   busy_r;

  logic                   grant_valid_s;
  logic                   grant_id_s;

  // Round-robin choice; on a tie the requester that was not served last wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (state_r == IDLE) begin
      grant_valid_s = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
        grant_id_s = ~last_grant_r;
      end else begin
        grant_id_s = req1_valid;
      end
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  assign req0_ready = grant_valid_s & ~grant_id_s;
  assign req1_ready = grant_valid_s &  grant_id_s;

  // Control FSM with operand, counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      resp_id_r    <= 1'b0;
      resp_data_r  <= '0;
      a_r          <= '0;
      b_r          <= '0;
      op_r         <= 3'd0;
      cnt_r        <= 4'd0;
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            a_r          <= grant_id_s ? req1_a  : req0_a;
            b_r          <= grant_id_s ? req1_b  : req0_b;
            op_r         <= grant_id_s ? req1_op : req0_op;
            last_grant_r <= grant_id_s;
            resp_id_r    <= grant_id_s;
            cnt_r        <= lat_load;
            busy_r       <= 1'b1;
            state_r      <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          if (cnt_r == 4'd0) begin
            resp_data_r  <= alu_result;
            resp_valid_r <= 1'b1;
            state_r      <= RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            state_r      <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign alu_a      = a_r;
  assign alu_b      = b_r;
  assign alu_op     = op_r;
  assign resp_valid = resp_valid_r;
  assign resp_id    = resp_id_r;
  assign resp_data  = resp_data_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_vec_alu_arbiter.sv
// Directed bench: one instance at alu_latency=1, one at alu_latency=4, each fed by a
// behavioural element-wise ALU; expected values are hand-computed constants.
module tb_vec_alu_arbiter;
  localparam int VS = 256;
  localparam int EW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // latency-1 instance signals
  logic          v0, v1, rdy0, rdy1, rsp_v, rsp_id, rsp_rdy, bsy;
  logic [VS-1:0] a0, b0, a1, b1, alu_a, alu_b, alu_res, rsp_d;
  logic [2:0]    op0, op1, alu_op;
  // latency-4 instance signals
  logic          w0, w_rdy0, w_rdy1, w_rsp_v, w_rsp_id, w_rsp_rdy, w_bsy;
  logic [VS-1:0] wa0, wb0, w_alu_a, w_alu_b, w_alu_res, w_rsp_d;
  logic [2:0]    wop0, w_alu_op;
  logic          w_zero = 1'b0;
  logic [VS-1:0] w_zvec = '0;
  logic [2:0]    w_zop = 3'd0;

  int tests = 0;
  int failed = 0;

  function automatic logic [VS-1:0] alu_model(input logic [VS-1:0] a, input logic [VS-1:0] b,
                                              input logic [2:0] op);
    logic [VS-1:0] r;
    r = '0;
    for (int e = 0; e < VS / EW; e++) begin
      case (op)
        3'd0:    r[e*EW +: EW] = a[e*EW +: EW] + b[e*EW +: EW];
        3'd1:    r[e*EW +: EW] = a[e*EW +: EW] - b[e*EW +: EW];
        3'd2:    r[e*EW +: EW] = a[e*EW +: EW] & b[e*EW +: EW];
        3'd3:    r[e*EW +: EW] = a[e*EW +: EW] | b[e*EW +: EW];
        3'd4:    r[e*EW +: EW] = a[e*EW +: EW] ^ b[e*EW +: EW];
        default: r[e*EW +: EW] = a[e*EW +: EW];
      endcase
    end
    return r;
  endfunction

  assign alu_res   = alu_model(alu_a, alu_b, alu_op);
  assign w_alu_res = alu_model(w_alu_a, w_alu_b, w_alu_op);

  vec_alu_arbiter #(.vector_size(VS), .element(EW), .alu_latency(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req1_valid(v1), .req0_ready(rdy0), .req1_ready(rdy1),
    .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1), .req0_op(op0), .req1_op(op1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_res),
    .resp_valid(rsp_v), .resp_id(rsp_id), .resp_data(rsp_d), .resp_ready(rsp_rdy), .busy(bsy)
  );

  vec_alu_arbiter #(.vector_size(VS), .element(EW), .alu_latency(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(w0), .req1_valid(w_zero), .req0_ready(w_rdy0), .req1_ready(w_rdy1),
    .req0_a(wa0), .req0_b(wb0), .req1_a(w_zvec), .req1_b(w_zvec), .req0_op(wop0), .req1_op(w_zop),
    .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_op(w_alu_op), .alu_result(w_alu_res),
    .resp_valid(w_rsp_v), .resp_id(w_rsp_id), .resp_data(w_rsp_d), .resp_ready(w_rsp_rdy), .busy(w_bsy)
  );

  task automatic chk(input string tag, input logic [VS-1:0] obs, input logic [VS-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [VS-1:0] exp_d;
    logic          exp_id;
    v0 = 1'b0; v1 = 1'b0; rsp_rdy = 1'b0;
    a0 = {16{16'h0003}}; b0 = {16{16'h0004}}; op0 = 3'd0;
    a1 = '0; b1 = '0; op1 = 3'd0;
    w0 = 1'b0; w_rsp_rdy = 1'b0;
    wa0 = {16{16'h0005}}; wb0 = {16{16'h0006}}; wop0 = 3'd0;

    // reset state
    #3;
    chk("rst_alu_a", alu_a, '0);
    chk("rst_alu_op", VS'(alu_op), '0);
    chk("rst_resp_valid", VS'(rsp_v), '0);
    chk("rst_resp_id", VS'(rsp_id), '0);
    chk("rst_resp_data", rsp_d, '0);
    chk("rst_busy", VS'(bsy), '0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("idle_no_req_ready", VS'({rdy1, rdy0}), VS'(2'b00));
    tick();
    chk("idle_no_req_busy", VS'(bsy), '0);

    // single op, then backpressure, held-off and withdrawn requests
    v0 = 1'b1;
    #1;
    chk("single_ready", VS'({rdy1, rdy0}), VS'(2'b01));
    tick();
    v0 = 1'b0;
    chk("single_exec_busy", VS'(bsy), VS'(1'b1));
    chk("single_exec_valid", VS'(rsp_v), '0);
    chk("single_alu_a", alu_a, {16{16'h0003}});
    tick();
    chk("single_resp_valid", VS'(rsp_v), VS'(1'b1));
    chk("single_resp_id", VS'(rsp_id), '0);
    chk("single_resp_data", rsp_d, {16{16'h0007}});
    v1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) v1 = 1'b0;
      #1;
      chk("bp_valid", VS'(rsp_v), VS'(1'b1));
      chk("bp_id", VS'(rsp_id), '0);
      chk("bp_data", rsp_d, {16{16'h0007}});
      chk("bp_ready_low", VS'({rdy1, rdy0}), VS'(2'b00));
      chk("bp_busy", VS'(bsy), VS'(1'b1));
      tick();
    end
    rsp_rdy = 1'b1;
    tick();
    chk("complete_valid", VS'(rsp_v), '0);
    chk("complete_busy", VS'(bsy), '0);
    chk("withdrawn_no_ready", VS'({rdy1, rdy0}), VS'(2'b00));
    tick();
    chk("withdrawn_no_transfer", VS'(bsy), '0);
    v0 = 1'b1;
    #1;
    chk("after_withdraw_grant", VS'({rdy1, rdy0}), VS'(2'b01));
    tick();
    v0 = 1'b0;
    tick();
    tick();

    // contention after reset: grants 0,1,0,1 and one response every 3 cycles
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    a0 = {16{16'h0001}}; b0 = {16{16'h0002}}; op0 = 3'd0;
    a1 = {16{16'h000a}}; b1 = {16{16'h0003}}; op1 = 3'd7;
    v0 = 1'b1; v1 = 1'b1; rsp_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id = k[0];
      exp_d  = exp_id ? {16{16'h000a}} : {16{16'h0003}};
      #1;
      chk("rr_ready", VS'({rdy1, rdy0}), exp_id ? VS'(2'b10) : VS'(2'b01));
      tick();
      chk("rr_alu_op", VS'(alu_op), exp_id ? VS'(3'd7) : VS'(3'd0));
      chk("rr_exec_valid", VS'(rsp_v), '0);
      tick();
      chk("rr_resp_valid", VS'(rsp_v), VS'(1'b1));
      chk("rr_resp_id", VS'(rsp_id), VS'(exp_id));
      chk("rr_resp_data", rsp_d, exp_d);
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;

    // latency sweep on the alu_latency=4 instance
    w0 = 1'b1;
    #1;
    chk("lat4_ready", VS'({w_rdy1, w_rdy0}), VS'(2'b01));
    tick();
    w0 = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("lat4_not_yet", VS'(w_rsp_v), '0);
      chk("lat4_alu_a", w_alu_a, {16{16'h0005}});
      chk("lat4_alu_b", w_alu_b, {16{16'h0006}});
      tick();
    end
    chk("lat4_not_yet", VS'(w_rsp_v), '0);
    tick();
    chk("lat4_resp_valid", VS'(w_rsp_v), VS'(1'b1));
    chk("lat4_resp_data", w_rsp_d, {16{16'h000b}});
    w_rsp_rdy = 1'b1;
    tick();
    chk("lat4_done", VS'(w_rsp_v), '0);

    // reset in the middle of EXEC
    w0 = 1'b1;
    tick();
    w0 = 1'b0;
    tick();
    chk("midop_busy_before", VS'(w_bsy), VS'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("midop_alu_a", w_alu_a, '0);
    chk("midop_alu_op", VS'(w_alu_op), '0);
    chk("midop_busy", VS'(w_bsy), '0);
    chk("midop_resp_valid", VS'(w_rsp_v), '0);
    chk("midop_resp_data", w_rsp_d, '0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("midop_no_resp", VS'(w_rsp_v), '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
